dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of core and memory address buses.
REQ-002 SHALL have parameter DATA_W, default 32, width of write and read data buses.
REQ-003 SHALL have parameter LOCK_MAX, default 15, maximum cycles a locked owner holds the port after its first granted access.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 C0_Req, C1_Req  input  1 each  core access request, held until granted.
REQ-007 C0_Write, C1_Write  input  1 each  1 = store, 0 = load; qualified by Req.
REQ-008 C0_Lock, C1_Lock  input  1 each  request to keep port ownership after grant (read-modify-write sequence).
REQ-009 C0_Address, C1_Address  input  ADDR_W each  byte address.
REQ-010 C0_WriteData, C1_WriteData  input  DATA_W each  store data.
REQ-011 C0_Stall, C1_Stall  output  1 each  request pending and not granted this cycle.
REQ-012 C0_ReadData, C1_ReadData  output  DATA_W each  registered load data.
REQ-013 C0_ReadValid, C1_ReadValid  output  1 each  one-cycle pulse, ReadData valid.
REQ-014 Mem_Address  output  ADDR_W  to data memory port A address.
REQ-015 Mem_WriteData  output  DATA_W  to data memory port A write data.
REQ-016 Mem_MemWrite, Mem_MemRead  output  1 each  memory strobes.
REQ-017 Mem_ReadData  input  DATA_W  memory port A read data, valid one cycle after the access cycle.

Function
REQ-018 States SHALL be IDLE, OWN0, OWN1; at most one core granted per cycle.
REQ-019 In IDLE, grant SHALL go to the sole requester; if both request, to the core selected by the round-robin pointer Prio.
REQ-020 Prio SHALL point to the non-granted core after every IDLE-state grant with both requesting; unchanged otherwise.
REQ-021 Grant SHALL be combinational in the request cycle; Mem_* SHALL carry the granted core's Address/WriteData, Mem_MemWrite = Write, Mem_MemRead = ~Write.
REQ-022 With no grant, Mem_MemWrite and Mem_MemRead SHALL be 0; Mem_Address and Mem_WriteData 0.
REQ-023 Cx_Stall SHALL equal Cx_Req AND NOT grant_x.
REQ-024 A granted load SHALL produce Cx_ReadValid = 1 and Cx_ReadData = Mem_ReadData exactly one cycle later; ReadData holds value otherwise.
REQ-025 A granted store SHALL produce no ReadValid.
REQ-026 IDLE -> OWNx when core x is granted with Cx_Lock = 1; a lock counter SHALL load 0.
REQ-027 In OWNx only core x SHALL be granted; other core stalls regardless of Prio.
REQ-028 OWNx -> IDLE when Cx_Lock = 0 (sampled at edge), or counter reaches LOCK_MAX; counter increments every OWNx cycle.
REQ-029 On forced release at LOCK_MAX, Prio SHALL point to the other core.
REQ-030 Cx_Lock with Cx_Req = 0 in IDLE SHALL be ignored.
REQ-031 Address and data SHALL pass unmodified; no byte/half alignment inside block.

Reset
REQ-032 Rst_n = 0 SHALL immediately force state IDLE, Prio = core 0, counter 0, ReadValid 0, ReadData 0, all grants 0 (Mem strobes 0, Stall = Req).
REQ-033 A load granted in the cycle reset asserts SHALL NOT produce ReadValid after reset release.
REQ-034 First rising edge after Rst_n deasserts SHALL be a normal arbitration cycle.

Verification
REQ-035 Only C0 load addr 0x40: cycle N Mem_MemRead = 1, Mem_Address = 0x40, C0_Stall = 0; N+1 C0_ReadValid = 1, C0_ReadData = memory word.
REQ-036 Both request every cycle, no Lock, from reset -> grants alternate C0, C1, C0, C1; each Stall high on alternate cycles.
REQ-037 C1 store 0xDEADBEEF to 0x80 with Lock held 3 cycles, C0 requesting -> C0_Stall = 1 for 3 cycles, then C0 granted next cycle.
REQ-038 C0 Lock held indefinitely, LOCK_MAX = 15 -> forced IDLE after 15 OWN0 cycles, C1 granted next cycle.
REQ-039 Rst_n pulsed low mid-OWN1 with load in flight -> strobes 0 immediately, no ReadValid, state IDLE, Prio = 0.
REQ-040 Simultaneous C0 store and C1 load, Prio = 1 -> C1 load granted, C0 store stalled one cycle, then written.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-core data-memory port arbiter: round-robin between cores when idle, with an
// optional bounded lock so one core can hold the port for read-modify-write sequences.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 15
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              C0_Req,
    input  logic              C0_Write,
    input  logic              C0_Lock,
    input  logic [ADDR_W-1:0] C0_Address,
    input  logic [DATA_W-1:0] C0_WriteData,
    input  logic              C1_Req,
    input  logic              C1_Write,
    input  logic              C1_Lock,
    input  logic [ADDR_W-1:0] C1_Address,
    input  logic [DATA_W-1:0] C1_WriteData,
    output logic              C0_Stall,
    output logic              C1_Stall,
    output logic [DATA_W-1:0] C0_ReadData,
    output logic [DATA_W-1:0] C1_ReadData,
    output logic              C0_ReadValid,
    output logic              C1_ReadValid,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_WriteData,
    output logic              Mem_MemWrite,
    output logic              Mem_MemRead,
    input  logic [DATA_W-1:0] Mem_ReadData
);

    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state, state_nxt;
    logic             prio, prio_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             grant0, grant1;
    logic             rd_vld0_p1, rd_vld1_p1;
    logic [DATA_W-1:0] rd_hold0_p1, rd_hold1_p1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (C0_Req && C1_Req && Rst_n) prio_nxt = grant0;
                if (grant0 && C0_Lock) begin
                    state_nxt = OWN0;
                    cnt_nxt   = '0;
                end else if (grant1 && C1_Lock) begin
                    state_nxt = OWN1;
                    cnt_nxt   = '0;
                end
            end
            OWN0: begin
                cnt_nxt = cnt + 1'b1;
                if (!C0_Lock) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b1;
                end
            end
            OWN1: begin
                cnt_nxt = cnt + 1'b1;
                if (!C1_Lock) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are gated by Rst_n so the memory port goes quiet the instant reset asserts.
    always_comb begin
        grant0        = 1'b0;
        grant1        = 1'b0;
        Mem_Address   = '0;
        Mem_WriteData = '0;
        Mem_MemWrite  = 1'b0;
        Mem_MemRead   = 1'b0;
        if (Rst_n) begin
            case (state)
                IDLE: begin
                    if (C0_Req && C1_Req) begin
                        grant0 = ~prio;
                        grant1 = prio;
                    end else begin
                        grant0 = C0_Req;
                        grant1 = C1_Req;
                    end
                end
                OWN0:    grant0 = C0_Req;
                OWN1:    grant1 = C1_Req;
                default: ;
            endcase
        end
        if (grant0) begin
            Mem_Address   = C0_Address;
            Mem_WriteData = C0_WriteData;
            Mem_MemWrite  = C0_Write;
            Mem_MemRead   = ~C0_Write;
        end else if (grant1) begin
            Mem_Address   = C1_Address;
            Mem_WriteData = C1_WriteData;
            Mem_MemWrite  = C1_Write;
            Mem_MemRead   = ~C1_Write;
        end
    end

    assign C0_Stall = C0_Req & ~grant0;
    assign C1_Stall = C1_Req & ~grant1;

    // Stage p1: memory returns load data the cycle after the access.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_vld0_p1  <= 1'b0;
            rd_vld1_p1  <= 1'b0;
            rd_hold0_p1 <= '0;
            rd_hold1_p1 <= '0;
        end else begin
            rd_vld0_p1 <= grant0 & ~C0_Write;
            rd_vld1_p1 <= grant1 & ~C1_Write;
            if (rd_vld0_p1) rd_hold0_p1 <= Mem_ReadData;
            if (rd_vld1_p1) rd_hold1_p1 <= Mem_ReadData;
        end
    end

    assign C0_ReadValid = rd_vld0_p1;
    assign C1_ReadValid = rd_vld1_p1;
    assign C0_ReadData  = rd_vld0_p1 ? Mem_ReadData : rd_hold0_p1;
    assign C1_ReadData  = rd_vld1_p1 ? Mem_ReadData : rd_hold1_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter: one table row per clock cycle, plus a
// hand-written sequence for reset asserted in the middle of a locked load.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wd;
    } core_t;

    typedef struct {
        logic        rst_n;
        core_t       c0;
        core_t       c1;
        logic [31:0] mem_rd;
        logic [1:0]  e_stall;
        logic [1:0]  e_strb;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_rv0;
        logic [31:0] e_rd0;
        logic        e_rv1;
        logic [31:0] e_rd1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_req, c0_wr, c0_lock, c1_req, c1_wr, c1_lock;
    logic [31:0] c0_addr, c0_wd, c1_addr, c1_wd, mem_rd;
    logic        c0_stall, c1_stall, c0_rv, c1_rv, mem_wr_s, mem_rd_s;
    logic [31:0] c0_rd, c1_rd, mem_addr, mem_wd;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];
    core_t none_c;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(15)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .C0_Req(c0_req), .C0_Write(c0_wr), .C0_Lock(c0_lock),
        .C0_Address(c0_addr), .C0_WriteData(c0_wd),
        .C1_Req(c1_req), .C1_Write(c1_wr), .C1_Lock(c1_lock),
        .C1_Address(c1_addr), .C1_WriteData(c1_wd),
        .C0_Stall(c0_stall), .C1_Stall(c1_stall),
        .C0_ReadData(c0_rd), .C1_ReadData(c1_rd),
        .C0_ReadValid(c0_rv), .C1_ReadValid(c1_rv),
        .Mem_Address(mem_addr), .Mem_WriteData(mem_wd),
        .Mem_MemWrite(mem_wr_s), .Mem_MemRead(mem_rd_s),
        .Mem_ReadData(mem_rd)
    );

    always #5 clk = ~clk;

    function automatic core_t ld(input logic [31:0] a, input logic l);
        ld = '{req: 1'b1, wr: 1'b0, lock: l, addr: a, wd: 32'h0};
    endfunction

    function automatic core_t st(input logic [31:0] a, input logic [31:0] d, input logic l);
        st = '{req: 1'b1, wr: 1'b1, lock: l, addr: a, wd: d};
    endfunction

    task automatic add(input logic r, input core_t a, input core_t b, input logic [31:0] m,
                       input logic [1:0] es, input logic [1:0] eb,
                       input logic [31:0] ea, input logic [31:0] ew,
                       input logic ev0, input logic [31:0] ed0,
                       input logic ev1, input logic [31:0] ed1);
        vec_t v;
        v.rst_n = r; v.c0 = a; v.c1 = b; v.mem_rd = m;
        v.e_stall = es; v.e_strb = eb; v.e_addr = ea; v.e_wd = ew;
        v.e_rv0 = ev0; v.e_rd0 = ed0; v.e_rv1 = ev1; v.e_rd1 = ed1;
        vecs.push_back(v);
    endtask

    task automatic drive(input core_t a, input core_t b);
        c0_req = a.req; c0_wr = a.wr; c0_lock = a.lock; c0_addr = a.addr; c0_wd = a.wd;
        c1_req = b.req; c1_wr = b.wr; c1_lock = b.lock; c1_addr = b.addr; c1_wd = b.wd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v, input int i);
        check($sformatf("v%0d stall{c0,c1}", i), 32'({c0_stall, c1_stall}), 32'(v.e_stall));
        check($sformatf("v%0d strobe{rd,wr}", i), 32'({mem_rd_s, mem_wr_s}), 32'(v.e_strb));
        check($sformatf("v%0d mem_addr", i), mem_addr, v.e_addr);
        check($sformatf("v%0d mem_wdata", i), mem_wd, v.e_wd);
        check($sformatf("v%0d readvalid{c0,c1}", i), 32'({c0_rv, c1_rv}), 32'({v.e_rv0, v.e_rv1}));
        check($sformatf("v%0d c0_readdata", i), c0_rd, v.e_rd0);
        check($sformatf("v%0d c1_readdata", i), c1_rd, v.e_rd1);
    endtask

    initial begin
        none_c = '0;
        drive(none_c, none_c);
        mem_rd = 32'h0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;

        // reset, then a lone C0 load and read-data hold
        add(1'b0, ld(32'h10, 1'b0), ld(32'h14, 1'b0), 32'h0, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, none_c, none_c, 32'h5555, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, ld(32'h40, 1'b0), none_c, 32'h0, 2'b00, 2'b10, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, none_c, none_c, 32'h12345678, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h12345678, 1'b0, 32'h0);
        add(1'b1, none_c, none_c, 32'hFFFFFFFF, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h12345678, 1'b0, 32'h0);
        // round-robin from reset
        add(1'b0, none_c, none_c, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, ld(32'h100, 1'b0), ld(32'h200, 1'b0), 32'h0, 2'b01, 2'b10, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b1, ld(32'h100, 1'b0), ld(32'h200, 1'b0), 32'hA0, 2'b10, 2'b10, 32'h200, 32'h0, 1'b1, 32'hA0, 1'b0, 32'h0);
        add(1'b1, ld(32'h100, 1'b0), ld(32'h200, 1'b0), 32'hB1, 2'b01, 2'b10, 32'h100, 32'h0, 1'b0, 32'hA0, 1'b1, 32'hB1);
        add(1'b1, ld(32'h100, 1'b0), ld(32'h200, 1'b0), 32'hC2, 2'b10, 2'b10, 32'h200, 32'h0, 1'b1, 32'hC2, 1'b0, 32'hB1);
        add(1'b1, none_c, none_c, 32'hD3, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'hC2, 1'b1, 32'hD3);
        // C0 store vs C1 load with Prio on C1
        add(1'b1, ld(32'h20, 1'b0), ld(32'h400, 1'b0), 32'h0, 2'b01, 2'b10, 32'h20, 32'h0, 1'b0, 32'hC2, 1'b0, 32'hD3);
        add(1'b1, st(32'h300, 32'h11111111, 1'b0), ld(32'h400, 1'b0), 32'h5A, 2'b10, 2'b10, 32'h400, 32'h0, 1'b1, 32'h5A, 1'b0, 32'hD3);
        add(1'b1, st(32'h300, 32'h11111111, 1'b0), none_c, 32'h6B, 2'b00, 2'b01, 32'h300, 32'h11111111, 1'b0, 32'h5A, 1'b1, 32'h6B);
        add(1'b1, none_c, none_c, 32'h77, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h5A, 1'b0, 32'h6B);
        // C1 locked store, C0 waits
        add(1'b1, ld(32'h20, 1'b0), ld(32'h24, 1'b0), 32'h0, 2'b01, 2'b10, 32'h20, 32'h0, 1'b0, 32'h5A, 1'b0, 32'h6B);
        add(1'b1, ld(32'h44, 1'b0), st(32'h80, 32'hDEADBEEF, 1'b1), 32'h15, 2'b10, 2'b01, 32'h80, 32'hDEADBEEF, 1'b1, 32'h15, 1'b0, 32'h6B);
        add(1'b1, ld(32'h44, 1'b0), st(32'h80, 32'hDEADBEEF, 1'b1), 32'h16, 2'b10, 2'b01, 32'h80, 32'hDEADBEEF, 1'b0, 32'h15, 1'b0, 32'h6B);
        add(1'b1, ld(32'h44, 1'b0), st(32'h80, 32'hDEADBEEF, 1'b0), 32'h17, 2'b10, 2'b01, 32'h80, 32'hDEADBEEF, 1'b0, 32'h15, 1'b0, 32'h6B);
        add(1'b1, ld(32'h44, 1'b0), none_c, 32'h18, 2'b00, 2'b10, 32'h44, 32'h0, 1'b0, 32'h15, 1'b0, 32'h6B);
        add(1'b1, none_c, none_c, 32'h99, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h99, 1'b0, 32'h6B);
        // Lock without Req is ignored
        add(1'b1, '{req: 1'b0, wr: 1'b0, lock: 1'b1, addr: 32'h0, wd: 32'h0}, none_c, 32'h0,
            2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h99, 1'b0, 32'h6B);
        add(1'b1, none_c, ld(32'h50, 1'b0), 32'h0, 2'b00, 2'b10, 32'h50, 32'h0, 1'b0, 32'h99, 1'b0, 32'h6B);
        add(1'b1, none_c, none_c, 32'h50AA, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h99, 1'b1, 32'h50AA);
        // C0 lock held past LOCK_MAX: forced release hands the port to C1
        add(1'b1, ld(32'h60, 1'b1), none_c, 32'h0, 2'b00, 2'b10, 32'h60, 32'h0, 1'b0, 32'h99, 1'b0, 32'h50AA);
        for (int k = 1; k <= 15; k++)
            add(1'b1, ld(32'h60, 1'b1), ld(32'h64, 1'b0), 32'h600 + 32'(k), 2'b01, 2'b10, 32'h60, 32'h0,
                1'b1, 32'h600 + 32'(k), 1'b0, 32'h50AA);
        add(1'b1, ld(32'h60, 1'b1), ld(32'h64, 1'b0), 32'h610, 2'b10, 2'b10, 32'h64, 32'h0, 1'b1, 32'h610, 1'b0, 32'h50AA);
        add(1'b1, ld(32'h60, 1'b1), ld(32'h64, 1'b0), 32'h611, 2'b01, 2'b10, 32'h60, 32'h0, 1'b0, 32'h610, 1'b1, 32'h611);
        add(1'b1, ld(32'h60, 1'b0), none_c, 32'h612, 2'b00, 2'b10, 32'h60, 32'h0, 1'b1, 32'h612, 1'b0, 32'h611);
        add(1'b1, none_c, none_c, 32'h613, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h613, 1'b0, 32'h611);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n  = vecs[i].rst_n;
            mem_rd = vecs[i].mem_rd;
            drive(vecs[i].c0, vecs[i].c1);
            @(negedge clk);
            check_vec(vecs[i], i);
            @(posedge clk);
            #1;
        end

        // reset pulsed while C1 owns the port with a load in flight
        drive(none_c, ld(32'h70, 1'b1));
        mem_rd = 32'h0;
        @(negedge clk);
        check("rst_seq own1 entry addr", mem_addr, 32'h70);
        @(posedge clk);
        #1;
        drive(ld(32'h74, 1'b0), ld(32'h70, 1'b1));
        @(negedge clk);
        check("rst_seq own1 stall{c0,c1}", 32'({c0_stall, c1_stall}), 32'(2'b10));
        check("rst_seq own1 strobe{rd,wr}", 32'({mem_rd_s, mem_wr_s}), 32'(2'b10));
        #1 rst_n = 1'b0;
        #1;
        check("rst_seq in-reset strobe{rd,wr}", 32'({mem_rd_s, mem_wr_s}), 32'(2'b00));
        check("rst_seq in-reset mem_addr", mem_addr, 32'h0);
        check("rst_seq in-reset stall{c0,c1}", 32'({c0_stall, c1_stall}), 32'(2'b11));
        check("rst_seq in-reset c0_readdata", c0_rd, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_rd = 32'hBAD0BAD0;
        @(negedge clk);
        check("rst_seq after readvalid{c0,c1}", 32'({c0_rv, c1_rv}), 32'(2'b00));
        check("rst_seq after c1_readdata", c1_rd, 32'h0);
        check("rst_seq after stall{c0,c1}", 32'({c0_stall, c1_stall}), 32'(2'b01));
        check("rst_seq after mem_addr", mem_addr, 32'h74);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
